// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU: single-cycle logic/arith ops, bit-serial SLL/SRL
module alu_multicycle #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            shamt,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Error,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_LUI = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_JR  = 4'b1000;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  dir_right_q, dir_right_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] comb_res;
    logic                  comb_err;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] shreg_next;

    // Single-cycle datapath; a shift by 0 also resolves here and returns B
    always_comb begin
        comb_res = '0;
        comb_err = 1'b0;
        unique case (ALUOperation)
            OP_AND:  comb_res = A & B;
            OP_OR:   comb_res = A | B;
            OP_LUI:  comb_res = DATA_WIDTH'(B[15:0]) << 16;
            OP_ADD:  comb_res = A + B;
            OP_SLL:  comb_res = B;
            OP_NOR:  comb_res = ~(A | B);
            OP_SRL:  comb_res = B;
            OP_SUB:  comb_res = A - B;
            OP_JR:   comb_res = A;
            default: comb_err = 1'b1;
        endcase
    end

    assign is_shift   = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign shreg_next = dir_right_q ? (shreg_q >> 1) : (shreg_q << 1);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        dir_right_d = dir_right_q;
        result_d    = result_q;
        zero_d      = zero_q;
        error_d     = error_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        shreg_d     = B;
                        cnt_d       = shamt;
                        dir_right_d = (ALUOperation == OP_SRL);
                        busy_d      = 1'b1;
                        state_d     = SHIFT;
                    end else begin
                        result_d = comb_res;
                        zero_d   = (comb_res == '0);
                        error_d  = comb_err;
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // start is deliberately ignored here; requests are not queued
                shreg_d = shreg_next;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shreg_next;
                    zero_d   = (shreg_next == '0);
                    error_d  = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dir_right_q <= dir_right_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Error     = error_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed scoreboard bench for alu_multicycle
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Error;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_multicycle #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
        .A(A), .B(B), .shamt(shamt), .ALUResult(ALUResult), .Zero(Zero),
        .Error(Error), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " result"}, ALUResult, e.res);
            check({tag, " zero"}, {31'd0, Zero}, {31'd0, e.zero});
            check({tag, " error"}, {31'd0, Error}, {31'd0, e.err});
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] exp_res, input logic exp_err);
        exp_t e;
        e.res  = exp_res;
        e.zero = (exp_res == 32'd0);
        e.err  = exp_err;
        sb_q.push_back(e);
        ALUOperation = op;
        A            = a;
        B            = b;
        shamt        = sh;
        start        = 1'b1;
    endtask

    // Waits (bounded) for done, checking latency and busy duration, then scores the result
    task automatic wait_done(input string tag, input int lat);
        int cycles = 0;
        int bcnt   = 0;
        do begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (busy) bcnt++;
        end while (!done && cycles < 40);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, cycles, lat);
        check({tag, " busy cycles"}, bcnt, lat - 1);
        check_pop(tag);
    endtask

    initial begin
        int dcount;
        reset = 1'b0;
        start = 1'b0;
        ALUOperation = 4'd0;
        A = '0;
        B = '0;
        shamt = '0;
        repeat (2) @(negedge clk);
        check("reset result", ALUResult, 32'd0);
        check("reset zero", {31'd0, Zero}, 32'd1);
        check("reset error", {31'd0, Error}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset mid-shift aborts the op; nothing is scored for it
        ALUOperation = 4'b0100; B = 32'd1; shamt = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort result", ALUResult, 32'd0);
        check("abort zero", {31'd0, Zero}, 32'd1);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort no done", dcount, 0);

        issue(4'b0000, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_0000, 1'b0);
        wait_done("AND", 1);
        issue(4'b0001, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_0FFF, 1'b0);
        wait_done("OR", 1);
        issue(4'b0101, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'hFFFF_F000, 1'b0);
        wait_done("NOR", 1);
        issue(4'b0111, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'hFFFF_F1E1, 1'b0);
        wait_done("SUB", 1);
        issue(4'b0010, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0F0F_0000, 1'b0);
        wait_done("LUI", 1);
        issue(4'b1000, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_00F0, 1'b0);
        wait_done("JR", 1);
        @(negedge clk);
        check("done one cycle", {31'd0, done}, 32'd0);

        issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0000_0000, 1'b0);
        wait_done("ADD wrap", 1);
        issue(4'b0111, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        wait_done("SUB wrap", 1);

        issue(4'b0100, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0);
        wait_done("SLL 31", 32);
        issue(4'b0110, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
        wait_done("SRL 4", 5);
        issue(4'b0100, 32'd0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0);
        wait_done("SLL 0", 1);
        issue(4'b0100, 32'd0, 32'hC000_0001, 5'd1, 32'h8000_0002, 1'b0);
        wait_done("SLL 1", 2);

        // start during SHIFT is dropped; operands changed after start must not matter
        issue(4'b0110, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
        @(negedge clk);
        ALUOperation = 4'b0011; A = 32'd5; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("SRL ignore start", 3);
        dcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("ignored start no done", dcount, 0);
        check("ignored start hold", ALUResult, 32'h0800_0000);

        // Back-to-back single-cycle ops
        issue(4'b0011, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);
        @(negedge clk);
        check("b2b 1 done", {31'd0, done}, 32'd1);
        check_pop("b2b 1");
        issue(4'b0011, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0);
        @(negedge clk);
        check("b2b 2 done", {31'd0, done}, 32'd1);
        check_pop("b2b 2");
        issue(4'b0011, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b 3 done", {31'd0, done}, 32'd1);
        check_pop("b2b 3");
        @(negedge clk);
        check("b2b end done", {31'd0, done}, 32'd0);

        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1);
        wait_done("op 1001", 1);
        issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1);
        wait_done("op 1111", 1);
        issue(4'b0011, 32'd4, 32'd5, 5'd0, 32'd9, 1'b0);
        wait_done("ADD after err", 1);

        check("scoreboard drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
